// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for the shared single-port memory, one transaction outstanding
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } state_e;

    state_e state_q;
    logic   idle;
    logic   force_if;
    logic   sel_if;
    logic   sel_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;

    assign force_if = (starve_q == CW'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch; any gap in if_req restarts it.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (d_gnt) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic starve_limit_unused;
    assign starve_limit_unused = (STARVE_LIMIT > 0);
    assign force_if            = 1'b0;
`endif

    // All outputs are forced low while rst is asserted, hence rst in every term.
    always_comb begin
        idle   = !rst && (state_q == IDLE);
        sel_if = idle && if_req && (!d_req || force_if);
        sel_d  = idle && d_req && !sel_if;

        mem_req   = sel_if || sel_d;
        mem_we    = sel_d && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (sel_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (sel_if) begin
            mem_addr  = if_addr;
            mem_be    = '1;
        end

        if_gnt    = sel_if && mem_gnt;
        d_gnt     = sel_d && mem_gnt;
        if_rvalid = !rst && mem_rvalid && (state_q == WAIT_IF);
        d_rvalid  = !rst && mem_rvalid && (state_q == WAIT_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

    // A response arriving in IDLE (stray or from an abandoned transaction) is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_gnt) begin
                        state_q <= WAIT_IF;
                    end else if (d_gnt) begin
                        state_q <= WAIT_D;
                    end
                end
                WAIT_IF, WAIT_D: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
